// File: rtl/counter4b_seq_pkg.sv
// Shared types and constants for the 4-bit counter sequencing controller.
package counter4b_seq_pkg;

    localparam int unsigned CNT_W             = 4;
    localparam int unsigned PERIOD_ZERO_TICKS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Counter value on the last tick of a segment; period 0 stands for a full 16-tick wrap.
    function automatic logic [CNT_W-1:0] seg_last(input logic [CNT_W-1:0] period);
        int unsigned len;
        len = (period == '0) ? PERIOD_ZERO_TICKS : 32'(period);
        return CNT_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/counter4b_seq_tick.sv
// Prescale tick generator: one tick every PRESC RUN cycles, restarted by clr.
// Only present when COUNTER4B_SEQ_PRESCALE_EN is defined.
`ifdef COUNTER4B_SEQ_PRESCALE_EN
module counter4b_seq_tick #(
    parameter int unsigned PRESC = 4
) (
    input  logic ck,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned DIV_W = (PRESC > 2) ? $clog2(PRESC) : 1;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_c = run && (div_q == DIV_W'(PRESC - 1));

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (run) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule
`endif

// File: rtl/counter4b_seq_ctrl.sv
// Sequencing controller for the 4-bit ripple counter: runs reps segments of period ticks.
// Optional prescaler enabled with COUNTER4B_SEQ_PRESCALE_EN.
module counter4b_seq_ctrl
    import counter4b_seq_pkg::*;
#(
    parameter int unsigned REP_W = 4,
    parameter int unsigned PRESC = 4
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    input  logic [CNT_W-1:0] cnt_q,
    input  logic             cnt_rc,
    output logic             cnt_clr,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] rep_cnt
);

    if (PRESC < 2) begin : g_presc_chk
        $error("counter4b_seq_ctrl: PRESC must be at least 2");
    end

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             tick_c;
    logic             at_last_c;
    logic             term_c;
    logic             cnt_clr_c;
    logic             cnt_en_c;

`ifdef COUNTER4B_SEQ_PRESCALE_EN
    counter4b_seq_tick #(
        .PRESC (PRESC)
    ) u_tick (
        .ck     (ck),
        .rst_n  (rst_n),
        .clr    (state_q == ST_CLEAR),
        .run    (state_q == ST_RUN),
        .tick_c (tick_c)
    );
`else
    assign tick_c = 1'b1;
`endif

    // A 16-tick segment ends on the counter's own carry rather than a value compare.
    assign at_last_c = (period_q == '0) ? cnt_rc : (cnt_q == seg_last(period_q));
    assign term_c    = tick_c && at_last_c;

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        cnt_clr_c = 1'b0;
        cnt_en_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    period_d  = period;
                    reps_d    = reps;
                    rep_cnt_d = '0;
                    state_d   = (reps != '0) ? ST_CLEAR : ST_DONE;
                end
            end
            ST_CLEAR: begin
                cnt_clr_c = 1'b1;
                state_d   = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                cnt_en_c = tick_c;
                if (abort) begin
                    cnt_clr_c = 1'b1;
                    state_d   = ST_IDLE;
                end else if (term_c) begin
                    cnt_clr_c = 1'b1;
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                    if (rep_cnt_d == reps_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign cnt_clr = cnt_clr_c;
    assign cnt_en  = cnt_en_c;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_counter4b_seq_ctrl.sv
// Bench for counter4b_seq_ctrl: behavioural 4-bit counter plus a timeline reference model.
module tb_counter4b_seq_ctrl;

    localparam int unsigned REP_W = 4;
`ifdef COUNTER4B_SEQ_PRESCALE_EN
    localparam int TPS = 4;
`else
    localparam int TPS = 1;
`endif

    logic             ck = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       period;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic [3:0]       cnt_q;
    logic             cnt_rc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] rep_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    counter4b_seq_ctrl #(
        .REP_W (REP_W),
        .PRESC (4)
    ) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .start   (start),
        .period  (period),
        .reps    (reps),
        .abort   (abort),
        .cnt_q   (cnt_q),
        .cnt_rc  (cnt_rc),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .busy    (busy),
        .done    (done),
        .rep_cnt (rep_cnt)
    );

    always #5 ck = ~ck;

    // Behavioural model of the counter stage being sequenced.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)       cnt_q <= 4'd0;
        else if (cnt_clr) cnt_q <= 4'd0;
        else if (cnt_en)  cnt_q <= cnt_q + 4'd1;
    end
    assign cnt_rc = (cnt_q == 4'hF);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One run from the start cycle (k=0) to the first idle cycle after it, checked every cycle.
    task automatic run(input logic [3:0] p, input logic [REP_W-1:0] r, input int abort_k,
                       input bit noise, input bit abort_at_start);
        int pl, kd, kend, j, ticks, e_rep;
        logic e_clr, e_en, e_busy, e_done;
        logic [3:0] e_q;
        bit chk_q;
        pl   = (p == 4'd0) ? 16 : int'(p);
        kd   = (r == '0) ? 1 : 2 + pl * int'(r) * TPS;
        kend = (abort_k > 0) ? abort_k : kd;
        start  = 1'b1;
        period = p;
        reps   = r;
        abort  = abort_at_start;
        #1;
        chk($sformatf("p%0d_r%0d_k0_busy", p, r), 32'(busy), 32'd0);
        chk($sformatf("p%0d_r%0d_k0_clr", p, r), 32'(cnt_clr), 32'd0);
        for (int k = 1; k <= kend + 1; k++) begin
            @(posedge ck);
            #1;
            start = 1'b0;
            abort = 1'b0;
            if (noise && k <= kend) begin
                start  = 1'($urandom);
                period = 4'($urandom);
                reps   = REP_W'($urandom);
            end
            if (noise && abort_k == 0 && k == kd) begin
                start = 1'b1;
                abort = 1'b1;
            end
            if (k == abort_k) abort = 1'b1;
            #1;
            e_clr  = 1'b0;
            e_en   = 1'b0;
            e_busy = (k <= kend);
            e_done = (abort_k == 0 && k == kd);
            e_q    = 4'd0;
            chk_q  = 1'b0;
            e_rep  = 0;
            if (r != '0) begin
                if (k == 1) begin
                    e_clr = 1'b1;
                end else if (k < kd && k <= kend) begin
                    j     = k - 2;
                    ticks = j / TPS;
                    e_en  = ((j % TPS) == TPS - 1);
                    e_q   = 4'(ticks % pl);
                    chk_q = 1'b1;
                    e_clr = (e_en && (ticks % pl == pl - 1)) || (k == abort_k);
                    e_rep = ticks / pl;
                end else if (abort_k > 0) begin
                    e_rep = (abort_k >= 2) ? ((abort_k - 2) / TPS) / pl : 0;
                end else begin
                    e_rep = int'(r);
                end
            end
            chk($sformatf("p%0d_r%0d_k%0d_busy", p, r, k), 32'(busy), 32'(e_busy));
            chk($sformatf("p%0d_r%0d_k%0d_done", p, r, k), 32'(done), 32'(e_done));
            chk($sformatf("p%0d_r%0d_k%0d_clr", p, r, k), 32'(cnt_clr), 32'(e_clr));
            chk($sformatf("p%0d_r%0d_k%0d_en", p, r, k), 32'(cnt_en), 32'(e_en));
            chk($sformatf("p%0d_r%0d_k%0d_rep", p, r, k), 32'(rep_cnt), 32'(e_rep));
            if (chk_q) chk($sformatf("p%0d_r%0d_k%0d_q", p, r, k), 32'(cnt_q), 32'(e_q));
        end
    endtask

    initial begin
        int rp, rr, rk;
        rst_n  = 1'b0;
        start  = 1'b0;
        period = 4'd0;
        reps   = '0;
        abort  = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_clr", 32'(cnt_clr), 32'd0);
        chk("rst_en", 32'(cnt_en), 32'd0);
        chk("rst_rep", 32'(rep_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge ck);
        #1;

        run(4'd3, 4'd2, 0, 1'b0, 1'b0);
        run(4'd0, 4'd1, 0, 1'b0, 1'b0);
        run(4'd7, 4'd0, 0, 1'b0, 1'b0);
        run(4'd5, 4'd3, 2 + 7 * TPS, 1'b0, 1'b0);
        run(4'd4, 4'd2, 0, 1'b1, 1'b1);
        run(4'd2, 4'd1, 1, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rp = int'($urandom_range(0, 15));
            rr = int'($urandom_range(0, 3));
            run(4'(rp), REP_W'(rr), 0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            rp = int'($urandom_range(1, 15));
            rr = int'($urandom_range(1, 3));
            rk = int'($urandom_range(2, 1 + rp * rr * TPS));
            run(4'(rp), REP_W'(rr), rk, 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of RUN clears every output without a clock edge.
        start  = 1'b1;
        period = 4'd6;
        reps   = REP_W'(2);
        @(posedge ck);
        #1;
        start = 1'b0;
        repeat (4) @(posedge ck);
        #3;
        chk("mid_run_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_clr", 32'(cnt_clr), 32'd0);
        chk("arst_en", 32'(cnt_en), 32'd0);
        chk("arst_rep", 32'(rep_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge ck);
        #1;
        run(4'd2, 4'd1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
